// File: rtl/bin_bcd_scan_driver.sv
// Binary to packed BCD (sequential double-dabble) with a multiplexed digit scan
// for a common-cathode display. Optional leading-zero blanking: LEAD_ZERO_BLANK_EN.
module bin_bcd_scan_driver #(
   parameter int unsigned BIN_W    = 14,
   parameter int unsigned DIGITS   = 4,
   parameter int unsigned SCAN_DIV = 100000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [BIN_W-1:0]  bin_in,
   input  logic              load,
   output logic              busy,
   output logic              overflow,
   output logic [3:0]        bcd_out,
   output logic [DIGITS-1:0] an
);

   localparam int unsigned BCD_W = 4 * DIGITS;
   localparam int unsigned CW    = $clog2(BIN_W + 1);
   localparam int unsigned SW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned IW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [63:0]       LP_LIMIT  = 64'(10) ** DIGITS;
   localparam logic [BCD_W-1:0]  LP_NINES  = {DIGITS{4'd9}};
   localparam logic [DIGITS-1:0] LP_AN_RST = ~DIGITS'(1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_COMMIT
   } state_t;

   state_t r_state;
   state_t w_state_next;

   logic                  w_start;
   logic                  w_shift;
   logic                  w_commit;
   logic                  w_ovf_in;

   logic [BIN_W-1:0]      r_bin;
   logic [BCD_W-1:0]      r_scratch;
   logic [CW-1:0]         r_cnt;
   logic                  r_ovf;
   logic [BCD_W-1:0]      r_disp;
   logic                  r_busy;
   logic                  r_overflow;

   logic [BCD_W-1:0]      w_adj;
   logic [BCD_W+BIN_W-1:0] w_shl;

   logic [SW-1:0]         r_scan;
   logic [IW-1:0]         r_idx;
   logic [3:0]            r_bcd;
   logic [DIGITS-1:0]     r_an;

   logic [3:0]            w_nib;
   logic [DIGITS-1:0]     w_lit;
   logic [DIGITS-1:0]     w_an;
   logic                  w_seen;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_start      = 1'b0;
      w_shift      = 1'b0;
      w_commit     = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (load) begin
               w_start      = 1'b1;
               w_state_next = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            w_shift = 1'b1;
            if (r_cnt == CW'(1)) begin
               w_state_next = ST_COMMIT;
            end
         end
         ST_COMMIT: begin
            w_commit     = 1'b1;
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // ----------------------------------------------------------- datapath
   assign w_ovf_in = (64'(bin_in) >= LP_LIMIT);

   always_comb begin
      w_adj = r_scratch;
      for (int unsigned k = 0; k < DIGITS; k++) begin
         if (r_scratch[4*k +: 4] >= 4'd5) begin
            w_adj[4*k +: 4] = r_scratch[4*k +: 4] + 4'd3;
         end
      end
   end

   // The top scratch bit falls off here; only values >= 10**DIGITS lose it,
   // and those are replaced by all nines at commit.
   assign w_shl = {w_adj, r_bin} << 1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_bin      <= '0;
         r_scratch  <= '0;
         r_cnt      <= '0;
         r_ovf      <= 1'b0;
         r_disp     <= '0;
         r_busy     <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         if (w_start) begin
            r_bin     <= bin_in;
            r_scratch <= '0;
            r_cnt     <= CW'(BIN_W);
            r_ovf     <= w_ovf_in;
            r_busy    <= 1'b1;
         end else if (w_shift) begin
            r_scratch <= w_shl[BCD_W+BIN_W-1:BIN_W];
            r_bin     <= w_shl[BIN_W-1:0];
            r_cnt     <= r_cnt - CW'(1);
         end else if (w_commit) begin
            r_disp     <= r_ovf ? LP_NINES : r_scratch;
            r_overflow <= r_ovf;
            r_busy     <= 1'b0;
         end
      end
   end

   assign busy     = r_busy;
   assign overflow = r_overflow;

   // --------------------------------------------------------------- scan
`ifdef LEAD_ZERO_BLANK_EN
   always_comb begin
      w_seen = 1'b0;
      w_lit  = '0;
      for (int unsigned j = 0; j < DIGITS; j++) begin
         w_seen = w_seen | (r_disp[4*(DIGITS-1-j) +: 4] != 4'd0);
         w_lit[DIGITS-1-j] = w_seen | ((DIGITS - 1 - j) == 0);
      end
   end
`else
   always_comb begin
      w_seen = 1'b1;
      w_lit  = '1;
   end
`endif

   always_comb begin
      w_nib = 4'd0;
      w_an  = '1;
      for (int unsigned k = 0; k < DIGITS; k++) begin
         if (r_idx == IW'(k)) begin
            w_nib   = r_disp[4*k +: 4];
            w_an[k] = ~w_lit[k];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_scan <= '0;
         r_idx  <= '0;
         r_bcd  <= 4'd0;
         r_an   <= LP_AN_RST;
      end else begin
         if (r_scan == SW'(SCAN_DIV - 1)) begin
            r_scan <= '0;
            r_idx  <= (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + IW'(1);
         end else begin
            r_scan <= r_scan + SW'(1);
         end
         r_bcd <= w_nib;
         r_an  <= w_an;
      end
   end

   assign bcd_out = r_bcd;
   assign an      = r_an;

endmodule
